sdram_port_arbiter: RTL and testbench

Shares the single SDRAM byte port between three requesters: the RAM eraser (cold-boot fill), the ROM/file downloader, and the CPU bus bridge. It sits between those masters and the SDRAM controller, serialises their transfers one at a time, and returns read data and a completion strobe to the owner. Fixed priority is used, with an anti-starvation guarantee for the CPU and a watchdog on reads the SDRAM controller never completes.

---
 rtl/sdram_port_arbiter_pkg.sv | 32 +++
 rtl/sdram_prio_pick.sv | 33 +++
 rtl/sdram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM byte-port arbiter: FSM states,
// requester indices and the byte returned when a read times out.
package sdram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_t;

   localparam logic [1:0] REQ_ERASER = 2'd0;
   localparam logic [1:0] REQ_DLOAD  = 2'd1;
   localparam logic [1:0] REQ_CPU    = 2'd2;
   localparam logic [1:0] OWNER_NONE = 2'd3;

   localparam logic [7:0] RD_FILL_BYTE = 8'hFF;

   // OWNER_NONE maps to no ack bit at all.
   function automatic logic [2:0] owner_onehot(input logic [1:0] idx);
      logic [2:0] v;
      v = 3'b000;
      case (idx)
         REQ_ERASER: v = 3'b001;
         REQ_DLOAD:  v = 3'b010;
         REQ_CPU:    v = 3'b100;
         default:    v = 3'b000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/sdram_prio_pick.sv
// Combinational winner selection: fixed priority eraser > downloader > CPU,
// overridden in favour of the CPU once it has been skipped MAX_SKIP times.
module sdram_prio_pick
   import sdram_port_arbiter_pkg::*;
#(
   parameter int MAX_SKIP = 4,
   parameter int SKIP_W   = 3
) (
   input  logic [2:0]        i_req,
   input  logic [SKIP_W-1:0] i_skip_cnt,
   output logic [1:0]        o_winner,
   output logic              o_valid
);

   logic w_cpu_forced;

   assign w_cpu_forced = i_req[REQ_CPU] && (i_skip_cnt >= SKIP_W'(MAX_SKIP));

   always_comb begin
      o_winner = OWNER_NONE;
      o_valid  = |i_req;
      if (w_cpu_forced) begin
         o_winner = REQ_CPU;
      end else if (i_req[REQ_ERASER]) begin
         o_winner = REQ_ERASER;
      end else if (i_req[REQ_DLOAD]) begin
         o_winner = REQ_DLOAD;
      end else if (i_req[REQ_CPU]) begin
         o_winner = REQ_CPU;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises eraser, downloader and CPU transfers onto the single SDRAM byte
// port, returning read data plus a one-cycle ack (and err on read timeout).
//
// state     | meaning
// ST_IDLE   | no owner; arbitrate and latch the winner's command
// ST_ISSUE  | mem_valid held until the controller accepts
// ST_RDWAIT | read accepted; wait for mem_rvalid or the timeout
// ST_DONE   | pulse ack (and err) to the owner, release ownership
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int MAX_SKIP   = 4,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [2:0]             i_req,
   input  logic [2:0][ADDR_W-1:0] i_addr,
   input  logic [2:0]             i_we,
   input  logic [2:0][7:0]        i_wdata,
   output logic [2:0]             o_ack,
   output logic [7:0]             o_rdata,
   output logic                   o_err,
   output logic [1:0]             o_owner,
   output logic                   o_mem_valid,
   output logic                   o_mem_we,
   output logic [ADDR_W-1:0]      o_mem_addr,
   output logic [7:0]             o_mem_wdata,
   input  logic                   i_mem_ready,
   input  logic                   i_mem_rvalid,
   input  logic [7:0]             i_mem_rdata
);

   localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
   localparam int TMO_W  = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

   arb_state_t          r_state;
   logic [2:0]          r_ack;
   logic                r_err;
   logic                r_err_flag;
   logic [7:0]          r_rdata;
   logic [1:0]          r_owner;
   logic                r_mem_valid;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [7:0]          r_mem_wdata;
   logic [SKIP_W-1:0]   r_skip_cnt;
   logic [TMO_W-1:0]    r_tmo_cnt;

   logic [1:0]          w_winner;
   logic                w_pick_valid;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic                w_sel_we;
   logic [7:0]          w_sel_wdata;
   logic                w_tmo_hit;

   sdram_prio_pick #(
      .MAX_SKIP (MAX_SKIP),
      .SKIP_W   (SKIP_W)
   ) u_prio_pick (
      .i_req      (i_req),
      .i_skip_cnt (r_skip_cnt),
      .o_winner   (w_winner),
      .o_valid    (w_pick_valid)
   );

   always_comb begin
      w_sel_addr  = i_addr[REQ_ERASER];
      w_sel_we    = i_we[REQ_ERASER];
      w_sel_wdata = i_wdata[REQ_ERASER];
      case (w_winner)
         REQ_DLOAD: begin
            w_sel_addr  = i_addr[REQ_DLOAD];
            w_sel_we    = i_we[REQ_DLOAD];
            w_sel_wdata = i_wdata[REQ_DLOAD];
         end
         REQ_CPU: begin
            w_sel_addr  = i_addr[REQ_CPU];
            w_sel_we    = i_we[REQ_CPU];
            w_sel_wdata = i_wdata[REQ_CPU];
         end
         default: ;
      endcase
   end

   // Last RDWAIT cycle: the counter holds the number of cycles already waited.
   assign w_tmo_hit = (r_tmo_cnt == TMO_W'(RD_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_ack       <= 3'b000;
         r_err       <= 1'b0;
         r_err_flag  <= 1'b0;
         r_rdata     <= 8'h00;
         r_owner     <= OWNER_NONE;
         r_mem_valid <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
         r_skip_cnt  <= '0;
         r_tmo_cnt   <= '0;
      end else begin
         r_ack <= 3'b000;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_owner     <= w_winner;
                  r_mem_valid <= 1'b1;
                  r_mem_we    <= w_sel_we;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_state     <= ST_ISSUE;
                  // Only grants that overtake a waiting CPU count as skips.
                  if ((w_winner == REQ_CPU) || !i_req[REQ_CPU]) begin
                     r_skip_cnt <= '0;
                  end else begin
                     r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
                  end
               end
            end
            ST_ISSUE: begin
               if (i_mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_tmo_cnt   <= '0;
                  r_err_flag  <= 1'b0;
                  r_state     <= r_mem_we ? ST_DONE : ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               if (i_mem_rvalid) begin
                  r_rdata <= i_mem_rdata;
                  r_state <= ST_DONE;
               end else if (w_tmo_hit) begin
                  r_rdata    <= RD_FILL_BYTE;
                  r_err_flag <= 1'b1;
                  r_state    <= ST_DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end
            ST_DONE: begin
               r_ack      <= owner_onehot(r_owner);
               r_err      <= r_err_flag;
               r_err_flag <= 1'b0;
               r_owner    <= OWNER_NONE;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_ack       = r_ack;
   assign o_err       = r_err;
   assign o_rdata     = r_rdata;
   assign o_owner     = r_owner;
   assign o_mem_valid = r_mem_valid;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reset, writes (with and without
// stall), reads, starvation order, back-to-back rate, timeout, mid-op reset.
module tb_sdram_port_arbiter;

   logic             clk;
   logic             reset_n;
   logic [2:0]       req;
   logic [2:0][24:0] addr;
   logic [2:0]       we;
   logic [2:0][7:0]  wdata;
   logic [2:0]       ack;
   logic [7:0]       rdata;
   logic             err;
   logic [1:0]       owner;
   logic             mem_valid;
   logic             mem_we;
   logic [24:0]      mem_addr;
   logic [7:0]       mem_wdata;
   logic             mem_ready;
   logic             mem_rvalid;
   logic [7:0]       mem_rdata;

   int checks = 0;
   int errors = 0;
   int exp_order [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

   sdram_port_arbiter #(
      .ADDR_W     (25),
      .MAX_SKIP   (4),
      .RD_TIMEOUT (255)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (reset_n),
      .i_req        (req),
      .i_addr       (addr),
      .i_we         (we),
      .i_wdata      (wdata),
      .o_ack        (ack),
      .o_rdata      (rdata),
      .o_err        (err),
      .o_owner      (owner),
      .o_mem_valid  (mem_valid),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_ready  (mem_ready),
      .i_mem_rvalid (mem_rvalid),
      .i_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset_n = 1'b0;
      req = 3'b111; we = 3'b111;
      addr[0] = 25'h00010; addr[1] = 25'h00020; addr[2] = 25'h00030;
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner got %0d want 3", owner); end
      checks++;
      if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", ack); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || owner !== 2'd0 || mem_addr !== 25'h00010) begin
         errors++;
         $display("FAIL reset_first_grant got valid=%b owner=%0d addr=%h want 1 0 00010", mem_valid, owner, mem_addr);
      end
      req = 3'b000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ack !== 3'b001) begin errors++; $display("FAIL reset_dropped_req_ack got %b want 001", ack); end
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL reset_drain got ack=%b valid=%b want 000 0", ack, mem_valid);
      end
   endtask

   task automatic test_single_write();
      req = 3'b010; we[1] = 1'b1; addr[1] = 25'h1099A; wdata[1] = 8'hFF;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h1099A || mem_wdata !== 8'hFF || owner !== 2'd1) begin
         errors++;
         $display("FAIL wr_cmd got valid=%b we=%b addr=%h wdata=%h owner=%0d want 1 1 1099a ff 1",
                  mem_valid, mem_we, mem_addr, mem_wdata, owner);
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL wr_accept got ack=%b valid=%b want 000 0", ack, mem_valid);
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b010 || owner !== 2'd3 || err !== 1'b0) begin
         errors++; $display("FAIL wr_ack got ack=%b owner=%0d err=%b want 010 3 0", ack, owner, err);
      end
      req = 3'b000;
      @(negedge clk);
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL wr_ack_width got %b want 000", ack); end
   endtask

   task automatic test_stalled_write();
      int bad;
      bad = 0;
      mem_ready = 1'b0;
      req = 3'b010; addr[1] = 25'h0ABCD; wdata[1] = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_valid !== 1'b1 || mem_addr !== 25'h0ABCD || mem_wdata !== 8'h3C || ack !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b0 || ack !== 3'b000) begin
         errors++; $display("FAIL stall_accept got valid=%b ack=%b want 0 000", mem_valid, ack);
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b010) begin errors++; $display("FAIL stall_ack got %b want 010", ack); end
      req = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_read();
      mem_rvalid = 1'b1; mem_rdata = 8'hA5;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (rdata !== 8'h00 || ack !== 3'b000) begin
         errors++; $display("FAIL rd_idle_rvalid got rdata=%h ack=%b want 00 000", rdata, ack);
      end
      req = 3'b100; we[2] = 1'b0; addr[2] = 25'h00123;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'h00123 || owner !== 2'd2) begin
         errors++;
         $display("FAIL rd_cmd got valid=%b we=%b addr=%h owner=%0d want 1 0 00123 2", mem_valid, mem_we, mem_addr, owner);
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL rd_wait_ack got %b want 000", ack); end
      mem_rvalid = 1'b1; mem_rdata = 8'h5A;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 8'h00;
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL rd_early_ack got %b want 000", ack); end
      @(negedge clk);
      checks++;
      if (ack !== 3'b100 || rdata !== 8'h5A || err !== 1'b0) begin
         errors++; $display("FAIL rd_ack got ack=%b rdata=%h err=%b want 100 5a 0", ack, rdata, err);
      end
      req = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      int n, cyc, last, idx;
      n = 0; cyc = 0; last = -1;
      req = 3'b111; we = 3'b111; mem_ready = 1'b1;
      while (n < 10 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (ack !== 3'b000) begin
            idx = (ack === 3'b001) ? 0 : (ack === 3'b010) ? 1 : (ack === 3'b100) ? 2 : 9;
            checks++;
            if (idx != exp_order[n]) begin
               errors++; $display("FAIL starve_order[%0d] got %0d want %0d", n, idx, exp_order[n]);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 3) begin
                  errors++; $display("FAIL back_to_back_spacing got %0d want 3", cyc - last);
               end
            end
            last = cyc;
            n++;
            if (n == 10) req = 3'b000;
         end
      end
      checks++;
      if (n != 10) begin errors++; $display("FAIL starve_budget got %0d acks want 10", n); end
      req = 3'b000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      req = 3'b100; we[2] = 1'b0; addr[2] = 25'h1F0F0; mem_ready = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1) begin errors++; $display("FAIL tmo_cmd got valid=%b want 1", mem_valid); end
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (ack !== 3'b000 || err !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL tmo_early got %0d early ack cycles want 0", bad); end
      @(negedge clk);
      checks++;
      if (ack !== 3'b100 || err !== 1'b1 || rdata !== 8'hFF || owner !== 2'd3) begin
         errors++;
         $display("FAIL tmo_ack got ack=%b err=%b rdata=%h owner=%0d want 100 1 ff 3", ack, err, rdata, owner);
      end
      req = 3'b000;
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || err !== 1'b0 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL tmo_after got ack=%b err=%b valid=%b want 000 0 0", ack, err, mem_valid);
      end
   endtask

   task automatic test_mid_reset();
      int bad;
      bad = 0;
      req = 3'b100; we[2] = 1'b0; addr[2] = 25'h00456; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b0; req = 3'b000;
      #1;
      checks++;
      if (owner !== 2'd3 || ack !== 3'b000 || rdata !== 8'h00) begin
         errors++; $display("FAIL midrst_async got owner=%0d ack=%b rdata=%h want 3 000 00", owner, ack, rdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 8'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (ack !== 3'b000 || rdata !== 8'h00 || owner !== 2'd3) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL midrst_late_rvalid got %0d bad cycles want 0", bad); end
      mem_ready = 1'b0;
      req = 3'b001; we[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1) begin errors++; $display("FAIL midrst_issue got valid=%b want 1", mem_valid); end
      reset_n = 1'b0; req = 3'b000;
      #1;
      checks++;
      if (mem_valid !== 1'b0 || owner !== 2'd3) begin
         errors++; $display("FAIL midrst_valid_drop got valid=%b owner=%0d want 0 3", mem_valid, owner);
      end
      @(negedge clk);
      reset_n = 1'b1; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (ack !== 3'b000 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_no_ack got ack=%b valid=%b want 000 0", ack, mem_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_stalled_write();
      test_read();
      test_starvation();
      test_timeout();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
